// File: rtl/sprite_pkg.sv
// Shared defaults and FSM encoding for the sprite blitter.
package sprite_pkg;

  localparam int unsigned SCREEN_W_DEF    = 320;
  localparam int unsigned SCREEN_H_DEF    = 240;
  localparam int unsigned TRANSPARENT_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth shift register that carries a payload DEPTH cycles, cleared on reset.
module pipe_delay #(
  parameter int unsigned DEPTH  = 1,
  parameter int unsigned DATA_W = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/sprite_blitter.sv
// Streams a WIDTH x HEIGHT sprite from ROM to the VGA write port at one pixel per cycle,
// with optional horizontal mirroring and clipping against the screen bounds.
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int unsigned WIDTH       = 28,
  parameter int unsigned HEIGHT      = 28,
  parameter int unsigned PIX_BITS    = 2,
  parameter int unsigned COLOUR_BITS = 1,
  parameter int unsigned ADDR_BITS   = 10,
  parameter int unsigned MEM_LATENCY = 1,
  parameter int unsigned TRANSPARENT = TRANSPARENT_DEF,
  parameter int unsigned SCREEN_W    = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H    = SCREEN_H_DEF
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start_render,
  input  logic [8:0]             base_x,
  input  logic [7:0]             base_y,
  input  logic                   flip_x,
  input  logic [PIX_BITS-1:0]    pic_data,
  output logic [ADDR_BITS-1:0]   pic_address,
  output logic [8:0]             x,
  output logic [7:0]             y,
  output logic [COLOUR_BITS-1:0] colour,
  output logic                   writeEn,
  output logic                   busy,
  output logic                   render_complete
);

  localparam int unsigned CX_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CY_W   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned LAT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int unsigned PIPE_W = 1 + CX_W + CY_W;

  state_t               state_q, state_d;
  logic [CX_W-1:0]      cx_q, cx_d, col;
  logic [CY_W-1:0]      cy_q, cy_d;
  logic [LAT_W-1:0]     drain_q, drain_d;
  logic [8:0]           bx_q;
  logic [7:0]           by_q;
  logic                 flip_q, flip_d, accept;
  logic [ADDR_BITS-1:0] addr_d;

  logic [PIPE_W-1:0]    pipe_in, pipe_out;
  logic                 d_valid;
  logic [CX_W-1:0]      d_cx;
  logic [CY_W-1:0]      d_cy;
  logic [9:0]           ex;
  logic [8:0]           ey;
  logic                 hit;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cx_q        <= '0;
      cy_q        <= '0;
      drain_q     <= '0;
      bx_q        <= '0;
      by_q        <= '0;
      flip_q      <= 1'b0;
      pic_address <= '0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      drain_q <= drain_d;
      flip_q  <= flip_d;
      if (accept) begin
        bx_q <= base_x;
        by_q <= base_y;
      end
      // Address register leads the counters so address k is visible in cycle k.
      if (state_d == FETCH) pic_address <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    drain_d = drain_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_render) begin
          state_d = FETCH;
          cx_d    = '0;
          cy_d    = '0;
          accept  = 1'b1;
        end
      end
      FETCH: begin
        if (cx_q == CX_W'(WIDTH - 1)) begin
          cx_d = '0;
          if (cy_q == CY_W'(HEIGHT - 1)) begin
            cy_d    = '0;
            drain_d = '0;
            state_d = DRAIN;
          end else begin
            cy_d = cy_q + CY_W'(1);
          end
        end else begin
          cx_d = cx_q + CX_W'(1);
        end
      end
      DRAIN: begin
        if (drain_q == LAT_W'(MEM_LATENCY - 1)) state_d = IDLE;
        else drain_d = drain_q + LAT_W'(1);
      end
      default: state_d = IDLE;
    endcase
    flip_d = accept ? flip_x : flip_q;
    col    = flip_d ? (CX_W'(WIDTH - 1) - cx_d) : cx_d;
    addr_d = ADDR_BITS'(32'(cy_d) * WIDTH) + ADDR_BITS'(col);
  end

  assign pipe_in = {state_q == FETCH, cx_q, cy_q};

  pipe_delay #(
    .DEPTH  (MEM_LATENCY),
    .DATA_W (PIPE_W)
  ) u_pipe (
    .clk    (clk),
    .resetn (resetn),
    .din    (pipe_in),
    .dout   (pipe_out)
  );

  assign {d_valid, d_cx, d_cy} = pipe_out;

  // Output stage is combinational on pic_data so pixel k leaves in cycle k+L.
  always_comb begin
    ex  = 10'(bx_q) + 10'(d_cx);
    ey  = 9'(by_q) + 9'(d_cy);
    hit = d_valid && (pic_data != PIX_BITS'(TRANSPARENT)) &&
          (ex < 10'(SCREEN_W)) && (ey < 9'(SCREEN_H));
    writeEn = hit;
    x       = hit ? ex[8:0] : '0;
    y       = hit ? ey[7:0] : '0;
    colour  = hit ? pic_data[COLOUR_BITS-1:0] : '0;
  end

  assign busy            = (state_q != IDLE);
  assign render_complete = d_valid && (d_cx == CX_W'(WIDTH - 1)) && (d_cy == CY_W'(HEIGHT - 1));

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: two instances (latency 1 / 2-bit ROM, latency 3 / 5-bit ROM)
// checked every cycle against a pixel-index model plus literal expectations.
module tb_sprite_blitter;

  localparam int W  = 28;
  localparam int H  = 28;
  localparam int N  = W * H;
  localparam int SW = 320;
  localparam int SH = 240;
  localparam int TR = 2;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start_render = 1'b0;
  logic       flip_x = 1'b0;
  logic [8:0] base_x = '0;
  logic [7:0] base_y = '0;

  int rom [N];
  int checks = 0;
  int errors = 0;
  int cycle = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic chk(input int inst, input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL u%0d %s: got %0d, expected %0d (cycle %0d)", inst, name, act, exp, cycle);
    end
  endtask

  function automatic int maddr(input int k, input bit f);
    int cx, cy;
    cx = k % W;
    cy = k / W;
    return cy * W + (f ? (W - 1 - cx) : cx);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L  = (g == 0) ? 1 : 3;
    localparam int PB = (g == 0) ? 2 : 5;

    logic [PB-1:0] pic_data;
    logic [9:0]    pic_address;
    logic [8:0]    x;
    logic [7:0]    y;
    logic [0:0]    colour;
    logic          write_en, busy, render_complete;

    int apipe [L];
    int mt = -1, bx = 0, by = 0;
    bit fl = 1'b0;
    int we_cnt = 0, rc_cnt = 0, rc_t = -1, rc_prev = 0, rc_last = 0;
    int first_we_t = -1, first_we_x = 0, first_we_y = 0;
    int low_run = 0, last_gap = 0;
    bit seen_busy = 1'b0;
    int a0 = -1, a27 = -1, x_l = -1, c_l = -1, we_l = -1;

    sprite_blitter #(
      .WIDTH(W), .HEIGHT(H), .PIX_BITS(PB), .COLOUR_BITS(1), .ADDR_BITS(10),
      .MEM_LATENCY(L), .TRANSPARENT(TR), .SCREEN_W(SW), .SCREEN_H(SH)
    ) dut (
      .clk(clk), .resetn(resetn), .start_render(start_render),
      .base_x(base_x), .base_y(base_y), .flip_x(flip_x),
      .pic_data(pic_data), .pic_address(pic_address),
      .x(x), .y(y), .colour(colour), .writeEn(write_en),
      .busy(busy), .render_complete(render_complete)
    );

    // ROM with L cycles of read latency
    always @(posedge clk) begin
      apipe[0] <= int'(pic_address);
      for (int i = 1; i < L; i++) apipe[i] <= apipe[i-1];
    end
    assign pic_data = PB'(rom[apipe[L-1] % N]);

    // Model: mt is the cycle index within the current render, -1 when idle
    always @(posedge clk or negedge resetn) begin
      if (!resetn) mt = -1;
      else if (mt < 0) begin
        if (start_render) begin
          mt = 0; bx = int'(base_x); by = int'(base_y); fl = flip_x;
        end
      end else if (mt == N + L - 1) mt = -1;
      else mt++;
    end

    always @(negedge clk) begin
      int k, wd, ex, ey;
      bit ew;
      if (!resetn) begin
        chk(g, "rst_busy", int'(busy), 0);
        chk(g, "rst_writeEn", int'(write_en), 0);
        chk(g, "rst_render_complete", int'(render_complete), 0);
        chk(g, "rst_pic_address", int'(pic_address), 0);
        chk(g, "rst_xyc", int'(x) + int'(y) + int'(colour), 0);
        seen_busy = 1'b0;
        low_run = 0;
      end else begin
        if (mt == 0) first_we_t = -1;
        ew = 1'b0; ex = 0; ey = 0; wd = 0;
        if (mt >= L) begin
          k  = mt - L;
          wd = rom[maddr(k, fl)] & ((1 << PB) - 1);
          ex = bx + k % W;
          ey = by + k / W;
          ew = (wd != TR) && (ex < SW) && (ey < SH);
        end
        chk(g, "busy", int'(busy), int'(mt >= 0));
        chk(g, "render_complete", int'(render_complete), int'(mt == N + L - 1));
        if (mt >= 0 && mt < N) chk(g, "pic_address", int'(pic_address), maddr(mt, fl));
        chk(g, "writeEn", int'(write_en), int'(ew));
        chk(g, "x", int'(x), ew ? ex : 0);
        chk(g, "y", int'(y), ew ? ey : 0);
        chk(g, "colour", int'(colour), ew ? (wd & 1) : 0);

        if (write_en) begin
          we_cnt++;
          if (first_we_t < 0) begin
            first_we_t = mt; first_we_x = int'(x); first_we_y = int'(y);
          end
        end
        if (render_complete) begin
          rc_cnt++; rc_t = mt; rc_prev = rc_last; rc_last = cycle;
        end
        if (busy) begin
          if (seen_busy && low_run > 0) last_gap = low_run;
          seen_busy = 1'b1;
          low_run = 0;
        end else low_run++;
        if (mt == 0)  a0  = int'(pic_address);
        if (mt == 27) a27 = int'(pic_address);
        if (mt == L) begin
          x_l = int'(x); c_l = int'(colour); we_l = int'(write_en);
        end
      end
    end
  end

  int we0, we1, rc0, rc1;

  task automatic snap();
    we0 = g_dut[0].we_cnt; we1 = g_dut[1].we_cnt;
    rc0 = g_dut[0].rc_cnt; rc1 = g_dut[1].rc_cnt;
  endtask

  task automatic render(input int bxv, input int byv, input bit f);
    @(posedge clk); #1;
    base_x = 9'(bxv); base_y = 8'(byv); flip_x = f; start_render = 1'b1;
    @(posedge clk); #1;
    start_render = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    repeat (2) @(posedge clk);
    while ((g_dut[0].mt >= 0 || g_dut[1].mt >= 0) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    chk(9, "idle_timeout", int'(n < 5000), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < N; k++) rom[k] = 0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (2) @(posedge clk);

    // Odd columns opaque, even transparent
    for (int k = 0; k < N; k++) rom[k] = (k % 2) ? 1 : TR;
    snap(); render(10, 20, 1'b0); wait_idle();
    chk(0, "t1_writes", g_dut[0].we_cnt - we0, 392);
    chk(1, "t1_writes", g_dut[1].we_cnt - we1, 392);
    chk(0, "t1_first_we_cycle", g_dut[0].first_we_t, 2);
    chk(1, "t1_first_we_cycle", g_dut[1].first_we_t, 4);
    chk(0, "t1_first_we_x", g_dut[0].first_we_x, 11);
    chk(0, "t1_first_we_y", g_dut[0].first_we_y, 20);
    chk(0, "t1_rc_cycle", g_dut[0].rc_t, 784);
    chk(1, "t1_rc_cycle", g_dut[1].rc_t, 786);
    chk(0, "t1_rc_count", g_dut[0].rc_cnt - rc0, 1);

    // Mirrored: each row holds 0..27
    for (int k = 0; k < N; k++) rom[k] = k % W;
    snap(); render(40, 50, 1'b1); wait_idle();
    chk(0, "t2_addr_c0", g_dut[0].a0, 27);
    chk(1, "t2_addr_c27", g_dut[1].a27, 0);
    chk(0, "t2_x_first", g_dut[0].x_l, 40);
    chk(0, "t2_colour_first", g_dut[0].c_l, 1);
    chk(1, "t2_colour_first", g_dut[1].c_l, 1);
    chk(1, "t2_we_first", g_dut[1].we_l, 1);

    // Clipped at bottom-right corner
    for (int k = 0; k < N; k++) rom[k] = 1;
    snap(); render(310, 230, 1'b0); wait_idle();
    chk(0, "t3_writes", g_dut[0].we_cnt - we0, 100);
    chk(1, "t3_writes", g_dut[1].we_cnt - we1, 100);
    chk(0, "t3_rc_cycle", g_dut[0].rc_t, 784);

    // Fully transparent
    for (int k = 0; k < N; k++) rom[k] = TR;
    snap(); render(0, 0, 1'b0); wait_idle();
    chk(0, "t4_writes", g_dut[0].we_cnt - we0, 0);
    chk(1, "t4_writes", g_dut[1].we_cnt - we1, 0);
    chk(1, "t4_rc_count", g_dut[1].rc_cnt - rc1, 1);
    chk(1, "t4_rc_cycle", g_dut[1].rc_t, 786);

    // Back-to-back renders: pulses N+L+1 edges apart, one idle cycle between
    for (int k = 0; k < N; k++) rom[k] = (k % 2) ? 1 : TR;
    snap();
    @(posedge clk); #1;
    base_x = 9'd100; base_y = 8'd100; flip_x = 1'b0; start_render = 1'b1;
    repeat (2000) @(posedge clk);
    #1 start_render = 1'b0;
    wait_idle();
    chk(0, "t5_rc_count", g_dut[0].rc_cnt - rc0, 3);
    chk(1, "t5_rc_count", g_dut[1].rc_cnt - rc1, 3);
    chk(0, "t5_rc_spacing", g_dut[0].rc_last - g_dut[0].rc_prev, 786);
    chk(1, "t5_rc_spacing", g_dut[1].rc_last - g_dut[1].rc_prev, 788);
    chk(0, "t5_busy_gap", g_dut[0].last_gap, 1);
    chk(1, "t5_busy_gap", g_dut[1].last_gap, 1);

    // Reset mid-render, then a clean render
    for (int k = 0; k < N; k++) rom[k] = 1;
    render(5, 5, 1'b0);
    repeat (300) @(posedge clk);
    @(negedge clk); #2;
    chk(0, "t6_busy_before", int'(g_dut[0].busy), 1);
    chk(1, "t6_busy_before", int'(g_dut[1].busy), 1);
    snap();
    resetn = 1'b0;
    #1;
    chk(0, "t6_async_we", int'(g_dut[0].write_en), 0);
    chk(0, "t6_async_busy", int'(g_dut[0].busy), 0);
    chk(1, "t6_async_we", int'(g_dut[1].write_en), 0);
    chk(1, "t6_async_busy", int'(g_dut[1].busy), 0);
    repeat (2) @(negedge clk);
    #2 resetn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk(0, "t6_no_rc", g_dut[0].rc_cnt - rc0, 0);
    chk(1, "t6_no_rc", g_dut[1].rc_cnt - rc1, 0);
    chk(0, "t6_no_we", g_dut[0].we_cnt - we0, 0);
    chk(1, "t6_idle_busy", int'(g_dut[1].busy), 0);
    snap(); render(5, 5, 1'b0); wait_idle();
    chk(0, "t6_writes", g_dut[0].we_cnt - we0, 784);
    chk(1, "t6_writes", g_dut[1].we_cnt - we1, 784);
    chk(0, "t6_rc_count", g_dut[0].rc_cnt - rc0, 1);
    chk(1, "t6_rc_count", g_dut[1].rc_cnt - rc1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
